dac_serializer: RTL and testbench

- Downstream consumer of the DigitalFilter output `yn`.
- Takes each 32-bit signed fixed-point filter sample and adds the mid-scale bias OFFSET (0x3FFFFF).
- Saturates the biased value to a 23-bit unsigned range, then quantizes it to a DAC_BITS code.
- Serializes the code MSB-first to an external SPI-style DAC, using a one-entry holding buffer and an overrun counter.

---
 rtl/dac_serializer_pkg.sv | 37 +++
 rtl/dac_serializer_if.sv | 26 ++
 rtl/dac_serializer_quantizer.sv | 25 ++
 rtl/dac_serializer.sv | 195 +++++++++++++++++++
 tb/tb_dac_serializer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/dac_serializer_pkg.sv
// dac_serializer_pkg
//   Shared types and helpers for the DAC serializer slice.
//   - dac_state_e : serializer FSM states (IDLE, LOAD, SHIFT, GAP)
//   - CMD_BITS / FRAME_BITS : command nibble width and default frame width
//   - quantize()  : clamp a biased sample to [0, 2^in_bits-1] and keep the
//                   top dac_bits bits (truncation, no rounding)
package dac_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } dac_state_e;

  localparam int CMD_BITS         = 4;
  localparam int DEFAULT_DAC_BITS = 12;
  localparam int FRAME_BITS       = CMD_BITS + DEFAULT_DAC_BITS;

  // Saturate the 33-bit biased value, then drop the low (in_bits-dac_bits) bits.
  function automatic logic [31:0] quantize(input logic signed [32:0] biased,
                                           input int in_bits,
                                           input int dac_bits);
    logic signed [32:0] limit_s;
    logic        [32:0] clamped_s;
    limit_s = (33'sd1 <<< in_bits) - 33'sd1;
    if (biased < 33'sd0) begin
      clamped_s = 33'd0;
    end else if (biased > limit_s) begin
      clamped_s = limit_s;
    end else begin
      clamped_s = biased;
    end
    quantize = 32'(clamped_s >> (in_bits - dac_bits));
  endfunction

endpackage

// File: rtl/dac_serializer_if.sv
// dac_serializer_if
//   Bundles the sample input side and the DAC/status output side.
//   - sample_in / sample_valid : filter sample and its one-cycle strobe
//   - dac_cs_n / dac_sclk / dac_mosi : SPI-style DAC pins
//   - busy / frame_done / overrun_cnt : status
//   master = sample producer / observer, slave = serializer.
interface dac_serializer_if;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic        dac_cs_n;
  logic        dac_sclk;
  logic        dac_mosi;
  logic        busy;
  logic        frame_done;
  logic [15:0] overrun_cnt;

  modport master (
    output sample_in, sample_valid,
    input  dac_cs_n, dac_sclk, dac_mosi, busy, frame_done, overrun_cnt
  );

  modport slave (
    input  sample_in, sample_valid,
    output dac_cs_n, dac_sclk, dac_mosi, busy, frame_done, overrun_cnt
  );
endinterface

// File: rtl/dac_serializer_quantizer.sv
// sample_quantizer
//   Purely combinational: bias the signed sample by OFFSET, clamp to the
//   unsigned IN_BITS range and truncate to a DAC_BITS code.
//   - sample_in : 32-bit signed filter sample
//   - code      : DAC_BITS-wide DAC code
module sample_quantizer
  import dac_serializer_pkg::*;
#(
  parameter logic [31:0] OFFSET   = 32'h003F_FFFF,
  parameter int          IN_BITS  = 23,
  parameter int          DAC_BITS = 12
) (
  input  logic [31:0]         sample_in,
  output logic [DAC_BITS-1:0] code
);

  logic signed [32:0] biased_s;

  // Sign-extend to 33 bits so the bias addition can never wrap.
  always_comb begin
    biased_s = $signed({sample_in[31], sample_in}) + $signed({1'b0, OFFSET});
    code     = DAC_BITS'(quantize(biased_s, IN_BITS, DAC_BITS));
  end

endmodule

// File: rtl/dac_serializer.sv
// dac_serializer
//   Quantizes filter samples into DAC codes and shifts {CMD, code} frames
//   MSB-first to an SPI-style DAC through a one-entry holding buffer.
//   - clk, rst (async, active low)
//   - bus (slave): sample_in, sample_valid, dac_cs_n, dac_sclk, dac_mosi,
//                  busy, frame_done, overrun_cnt (saturating drop count)
module dac_serializer
  import dac_serializer_pkg::*;
#(
  parameter logic [31:0] OFFSET     = 32'h003F_FFFF,
  parameter int          IN_BITS    = 23,
  parameter int          DAC_BITS   = 12,
  parameter logic [3:0]  CMD        = 4'h3,
  parameter int          SCLK_DIV   = 2,
  parameter int          GAP_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  dac_serializer_if.slave bus
);

  localparam int FRAME_W = CMD_BITS + DAC_BITS;
  localparam int CNT_W   = 8;
  localparam int BIT_W   = $clog2(FRAME_W + 1);

  dac_state_e           state_r;
  dac_state_e           state_next_s;
  logic [DAC_BITS-1:0]  code_s;
  logic [DAC_BITS-1:0]  hold_r;
  logic                 hold_valid_r;
  logic                 hold_valid_next_s;
  logic [FRAME_W-1:0]   frame_s;
  logic [FRAME_W-2:0]   shift_r;   // bits still to send; MSB already on mosi
  logic [CNT_W-1:0]     div_r;     // sclk divider in SHIFT, gap timer in GAP
  logic [BIT_W-1:0]     bit_r;
  logic                 cs_n_r, sclk_r, mosi_r, busy_r, frame_done_r;
  logic [15:0]          overrun_r;
  logic                 rst_done_r;
  logic                 consume_s, accept_s, drop_s;
  logic                 div_tc_s, last_fall_s, gap_end_s;

  sample_quantizer #(
    .OFFSET   (OFFSET),
    .IN_BITS  (IN_BITS),
    .DAC_BITS (DAC_BITS)
  ) u_quant (
    .sample_in (bus.sample_in),
    .code      (code_s)
  );

  // Hold-buffer handshake, timing events and next-state selection.
  always_comb begin
    frame_s           = {CMD, hold_r};
    consume_s         = (state_r == LOAD);
    accept_s          = bus.sample_valid && rst_done_r && (!hold_valid_r || consume_s);
    drop_s            = bus.sample_valid && rst_done_r && hold_valid_r && !consume_s;
    div_tc_s          = (div_r == CNT_W'(SCLK_DIV - 1));
    last_fall_s       = (state_r == SHIFT) && div_tc_s && sclk_r &&
                        (bit_r == BIT_W'(FRAME_W - 1));
    gap_end_s         = (state_r == GAP) && (div_r == CNT_W'(GAP_CYCLES - 1));
    hold_valid_next_s = hold_valid_r;
    if (accept_s) begin
      hold_valid_next_s = 1'b1;
    end else if (consume_s) begin
      hold_valid_next_s = 1'b0;
    end else begin
      hold_valid_next_s = hold_valid_r;
    end
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (hold_valid_r) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: state_next_s = SHIFT;
      SHIFT: begin
        if (last_fall_s) begin
          state_next_s = GAP;
        end else begin
          state_next_s = SHIFT;
        end
      end
      GAP: begin
        if (gap_end_s && hold_valid_r) begin
          state_next_s = LOAD;
        end else if (gap_end_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = GAP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Holding buffer, overrun counter and the strobe mask for the release cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_r       <= '0;
      hold_valid_r <= 1'b0;
      overrun_r    <= 16'd0;
      rst_done_r   <= 1'b0;
    end else begin
      rst_done_r   <= 1'b1;
      hold_valid_r <= hold_valid_next_s;
      if (accept_s) begin
        hold_r <= code_s;
      end
      if (drop_s && (overrun_r != 16'hFFFF)) begin
        overrun_r <= overrun_r + 16'd1;
      end
    end
  end

  // Serial datapath: divider, sclk, shifter, chip select and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r      <= '0;
      div_r        <= '0;
      bit_r        <= '0;
      cs_n_r       <= 1'b1;
      sclk_r       <= 1'b0;
      mosi_r       <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      busy_r       <= (state_next_s != IDLE) || hold_valid_next_s;
      frame_done_r <= last_fall_s;
      case (state_r)
        IDLE: begin
          cs_n_r <= 1'b1;
          sclk_r <= 1'b0;
          div_r  <= '0;
          bit_r  <= '0;
        end
        LOAD: begin
          shift_r <= frame_s[FRAME_W-2:0];
          mosi_r  <= frame_s[FRAME_W-1];
          cs_n_r  <= 1'b0;
          sclk_r  <= 1'b0;
          div_r   <= '0;
          bit_r   <= '0;
        end
        SHIFT: begin
          if (div_tc_s) begin
            div_r  <= '0;
            sclk_r <= ~sclk_r;
            // Data advances only on the 1->0 sclk transition.
            if (sclk_r) begin
              shift_r <= {shift_r[FRAME_W-3:0], 1'b0};
              mosi_r  <= shift_r[FRAME_W-2];
              bit_r   <= bit_r + BIT_W'(1);
              if (last_fall_s) begin
                cs_n_r <= 1'b1;
              end
            end
          end else begin
            div_r <= div_r + CNT_W'(1);
          end
        end
        GAP: begin
          cs_n_r <= 1'b1;
          sclk_r <= 1'b0;
          div_r  <= gap_end_s ? CNT_W'(0) : div_r + CNT_W'(1);
        end
        default: begin
          cs_n_r <= 1'b1;
          sclk_r <= 1'b0;
          div_r  <= '0;
          bit_r  <= '0;
        end
      endcase
    end
  end

  assign bus.dac_cs_n    = cs_n_r;
  assign bus.dac_sclk    = sclk_r;
  assign bus.dac_mosi    = mosi_r;
  assign bus.busy        = busy_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.overrun_cnt = overrun_r;

endmodule

// File: tb/tb_dac_serializer.sv
// tb_dac_serializer
//   Two serializers: instance 0 at default timing (SCLK_DIV=2, GAP=2) and
//   instance 1 at SCLK_DIV=1, GAP=1. A timeline model predicts, for every
//   cycle, cs_n/sclk/mosi/busy/frame_done/overrun from the accepted-sample
//   load times and the frame period.
module tb_dac_serializer;

  localparam int DIV0 = 2, GAP0 = 2, DIV1 = 1, GAP1 = 1;
  localparam int MAXF = 512, MAXD = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac_serializer_if b0 ();
  dac_serializer_if b1 ();

  dac_serializer #(.SCLK_DIV(DIV0), .GAP_CYCLES(GAP0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  dac_serializer #(.SCLK_DIV(DIV1), .GAP_CYCLES(GAP1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  int          acc_t [2][MAXF];
  int          ld_t  [2][MAXF];
  logic [15:0] fr_v  [2][MAXF];
  int          dr_t  [2][MAXD];
  int          n_fr  [2];
  int          n_dr  [2];

  logic [1:0]  cs_n_o, sclk_o, mosi_o, busy_o, fd_o;
  logic [15:0] ovr_o [2];
  assign cs_n_o = {b1.dac_cs_n, b0.dac_cs_n};
  assign sclk_o = {b1.dac_sclk, b0.dac_sclk};
  assign mosi_o = {b1.dac_mosi, b0.dac_mosi};
  assign busy_o = {b1.busy, b0.busy};
  assign fd_o   = {b1.frame_done, b0.frame_done};
  assign ovr_o[0] = b0.overrun_cnt;
  assign ovr_o[1] = b1.overrun_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? DIV0 : DIV1;
  endfunction

  function automatic int frame_cycles(input int i);
    return 1 + 2 * 16 * div_of(i) + ((i == 0) ? GAP0 : GAP1);
  endfunction

  // Reference quantizer: bias, clamp to [0, 2^23-1], keep top 12 bits.
  function automatic logic [15:0] ref_frame(input logic [31:0] v);
    longint b;
    b = longint'($signed(v)) + 64'sd4194303;
    if (b < 64'sd0) b = 64'sd0;
    if (b > 64'sd8388607) b = 64'sd8388607;
    return {4'h3, 12'(b >>> 11)};
  endfunction

  // A strobe at cycle t is taken if the slot is free or consumed at t;
  // its LOAD is 2 cycles later or right after the previous frame's GAP.
  task automatic model_strobe(input int i, input int t, input logic [31:0] v);
    int k;
    k = n_fr[i];
    if (k == 0 || t >= ld_t[i][k-1]) begin
      if (k < MAXF) begin
        acc_t[i][k] = t;
        ld_t[i][k]  = (k == 0) ? t + 2 : ((t + 2 > ld_t[i][k-1] + frame_cycles(i)) ?
                                          t + 2 : ld_t[i][k-1] + frame_cycles(i));
        fr_v[i][k]  = ref_frame(v);
        n_fr[i]     = k + 1;
      end
    end else if (n_dr[i] < MAXD) begin
      dr_t[i][n_dr[i]] = t;
      n_dr[i]++;
    end
  endtask

  task automatic check_cycle(input int i, input int c);
    int sh, fc, dv, o, e_ovr;
    bit e_busy, e_cs, e_sclk, e_mosi, e_fd, win;
    string pfx;
    dv = div_of(i); sh = 2 * 16 * dv; fc = frame_cycles(i);
    e_busy = 1'b0; e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_fd = 1'b0; win = 1'b0;
    for (int k = 0; k < n_fr[i]; k++) begin
      if (c >= acc_t[i][k] + 1 && c <= ld_t[i][k] + fc - 1) e_busy = 1'b1;
      if (c >= ld_t[i][k] + 1 && c <= ld_t[i][k] + sh) begin
        o = c - ld_t[i][k] - 1;
        e_cs = 1'b0; win = 1'b1;
        e_sclk = ((o / dv) % 2) == 1;
        e_mosi = fr_v[i][k][15 - o / (2 * dv)];
      end
      if (c == ld_t[i][k] + sh + 1) e_fd = 1'b1;
    end
    e_ovr = 0;
    for (int k = 0; k < n_dr[i]; k++) if (dr_t[i][k] < c) e_ovr++;
    if (e_ovr > 65535) e_ovr = 65535;
    pfx = $sformatf("i%0d@%0d", i, c);
    check({pfx, " cs_n"}, 32'(cs_n_o[i]), 32'(e_cs));
    check({pfx, " sclk"}, 32'(sclk_o[i]), 32'(e_sclk));
    check({pfx, " busy"}, 32'(busy_o[i]), 32'(e_busy));
    check({pfx, " frame_done"}, 32'(fd_o[i]), 32'(e_fd));
    check({pfx, " overrun"}, 32'(ovr_o[i]), 32'(e_ovr));
    if (win) check({pfx, " mosi"}, 32'(mosi_o[i]), 32'(e_mosi));
  endtask

  always @(negedge clk) begin
    if (rst && chk_en) begin
      for (int i = 0; i < 2; i++) check_cycle(i, cyc);
    end
  end

  task automatic step(input bit e0, input logic [31:0] d0, input bit e1, input logic [31:0] d1);
    @(negedge clk);
    b0.sample_valid = e0; b0.sample_in = d0;
    b1.sample_valid = e1; b1.sample_in = d1;
    if (e0) model_strobe(0, cyc, d0);
    if (e1) model_strobe(1, cyc, d1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  function automatic logic [31:0] rand_sample();
    case ($urandom_range(0, 3))
      0: return 32'($urandom);
      1: return 32'($urandom_range(0, 32'h00A0_0000)) - 32'h0050_0000;
      2: return 32'hFFC0_0000 + 32'($urandom_range(0, 4));
      3: return 32'h003F_FFFD + 32'($urandom_range(0, 4));
      default: return 32'd0;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      n_fr[i] = 0;
      n_dr[i] = 0;
    end
  endtask

  task automatic check_async_reset(input string tag);
    check({tag, " cs_n"}, 32'(b0.dac_cs_n), 32'd1);
    check({tag, " sclk"}, 32'(b0.dac_sclk), 32'd0);
    check({tag, " mosi"}, 32'(b0.dac_mosi), 32'd0);
    check({tag, " busy"}, 32'(b0.busy), 32'd0);
    check({tag, " frame_done"}, 32'(b0.frame_done), 32'd0);
    check({tag, " overrun"}, 32'(b0.overrun_cnt), 32'd0);
    check({tag, " i1 cs_n"}, 32'(b1.dac_cs_n), 32'd1);
    check({tag, " i1 busy"}, 32'(b1.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] dir_vals [5];
    dir_vals[0] = 32'h0000_0000; dir_vals[1] = 32'hFFC0_0001; dir_vals[2] = 32'hFF00_0000;
    dir_vals[3] = 32'h0040_0000; dir_vals[4] = 32'h0050_0000;
    clear_model();
    b0.sample_valid = 1'b0; b0.sample_in = 32'd0;
    b1.sample_valid = 1'b0; b1.sample_in = 32'd0;

    // Power-on reset values.
    #1 rst = 1'b0;
    #2 check_async_reset("por");
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    idle(4);

    // Quantization: mid-scale, minimum, clamp low, full scale, clamp high.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, dir_vals[k], 1'b1, dir_vals[k]);
      idle(80);
    end

    // Buffering and overrun: strobes 10 cycles apart, third one dropped.
    step(1'b1, 32'h0000_0000, 1'b0, 32'd0);
    idle(9);
    step(1'b1, 32'h0040_0000, 1'b0, 32'd0);
    idle(9);
    step(1'b1, 32'hFFC0_0001, 1'b0, 32'd0);
    idle(160);
    check("buf overrun_cnt", 32'(b0.overrun_cnt), 32'd1);
    check("buf busy_low", 32'(b0.busy), 32'd0);

    // Reset asserted while bit 7 of the frame is on the wire.
    step(1'b1, 32'h0000_0000, 1'b0, 32'd0);
    idle(2 + 1 + 7 * 2 * DIV0);
    check("mid cs_n_low", 32'(b0.dac_cs_n), 32'd0);
    #2 rst = 1'b0;
    #1 check_async_reset("midrst");
    clear_model();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    idle(3);
    step(1'b1, 32'h0000_0000, 1'b0, 32'd0);
    idle(80);

    // Fast instance: strobes 35 cycles apart never overrun.
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 32'd0, 1'b1, rand_sample());
      idle(34);
    end
    idle(40);
    check("fast overrun_cnt", 32'(b1.overrun_cnt), 32'd0);

    // Randomized traffic on both instances.
    for (int k = 0; k < 2500; k++) begin
      step($urandom_range(0, 39) == 0, rand_sample(), $urandom_range(0, 29) == 0, rand_sample());
    end
    idle(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
